// File: rtl/cntr_pkg.sv
// Shared definitions for the up/down counters and their observers.
// Direction encoding must match the counters' up_down input.
package cntr_pkg;

  localparam int CNTR_WIDTH_DEF = 3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERR   = 2'd2
  } dir_state_t;

endpackage

// File: rtl/cntr_delta_cls.sv
// Combinational step classifier: compares two successive count samples
// modulo 2^WIDTH, so counter wrap counts as an ordinary +/-1 step.
module cntr_delta_cls
  import cntr_pkg::*;
#(
  parameter int WIDTH = CNTR_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] prev,
  output logic             is_up,
  output logic             is_dn,
  output logic             is_hold,
  output logic             is_jump
);

  logic [WIDTH-1:0] delta;

  assign delta   = cur - prev;
  assign is_up   = (delta == WIDTH'(1));
  assign is_dn   = (delta == '1);
  assign is_hold = (delta == '0);
  assign is_jump = ~(is_up | is_dn | is_hold);

endmodule

// File: rtl/cntr_dir_decoder.sv
// Recovers direction, net position and reversal count from an observed
// up/down counter bus; flags and latches illegal jumps.
//
// state    | meaning
// ST_INIT  | seed prev from the current sample, no step/hold
// ST_TRACK | classify each sample against prev and update outputs
// ST_ERR   | illegal jump seen; outputs frozen until err_clr
module cntr_dir_decoder
  import cntr_pkg::*;
#(
  parameter int WIDTH = CNTR_WIDTH_DEF,
  parameter int POS_W = 16,
  parameter int REV_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        bin_count,
  input  logic                    err_clr,
  output logic                    up_down,
  output logic                    step,
  output logic                    hold,
  output logic                    jump_err,
  output logic signed [POS_W-1:0] position,
  output logic [REV_W-1:0]        rev_count
);

  dir_state_t       state;
  logic [WIDTH-1:0] prev;
  logic             have_dir;
  logic             is_up, is_dn, is_hold, is_jump;
  logic             new_dir;

  cntr_delta_cls #(.WIDTH(WIDTH)) u_cls (
    .cur     (bin_count),
    .prev    (prev),
    .is_up   (is_up),
    .is_dn   (is_dn),
    .is_hold (is_hold),
    .is_jump (is_jump)
  );

  assign new_dir = is_dn ? DIR_DN : DIR_UP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      prev      <= '0;
      have_dir  <= 1'b0;
      up_down   <= DIR_UP;
      step      <= 1'b0;
      hold      <= 1'b0;
      jump_err  <= 1'b0;
      position  <= '0;
      rev_count <= '0;
    end else begin
      step <= 1'b0;
      hold <= 1'b0;
      case (state)
        ST_INIT: begin
          prev  <= bin_count;
          state <= ST_TRACK;
        end
        ST_TRACK: begin
          prev <= bin_count;
          if (is_up || is_dn) begin
            step     <= 1'b1;
            up_down  <= new_dir;
            have_dir <= 1'b1;
            position <= is_dn ? position - POS_W'(1) : position + POS_W'(1);
            // the very first step only establishes a direction
            if (have_dir && (new_dir != up_down) && (rev_count != '1))
              rev_count <= rev_count + REV_W'(1);
          end else if (is_hold) begin
            hold <= 1'b1;
          end else if (is_jump) begin
            jump_err <= 1'b1;
            state    <= ST_ERR;
          end
        end
        ST_ERR: begin
          prev <= bin_count;
          if (err_clr) begin
            jump_err <= 1'b0;
            state    <= ST_INIT;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cntr_dir_decoder.sv
// Randomised and directed check of cntr_dir_decoder against a behavioural
// model; a second instance with REV_W=2 exercises reversal saturation.
module tb_cntr_dir_decoder;

  localparam int W = 3;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] bin_count = '0;
  logic         err_clr = 1'b0;

  logic         ud_a, step_a, hold_a, err_a;
  logic [15:0]  pos_a;
  logic [7:0]   rev_a;
  logic         ud_b, step_b, hold_b, err_b;
  logic [15:0]  pos_b;
  logic [1:0]   rev_b;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // model state: mode 0 = seeding, 1 = tracking, 2 = error
  int m_mode = 0, m_prev = 0, m_pos = 0, m_rev = 0, m_rev2 = 0;
  bit m_have = 0, m_dir = 0, m_step = 0, m_hold = 0, m_err = 0;

  cntr_dir_decoder #(.WIDTH(W), .POS_W(16), .REV_W(8)) dut_a (
    .clk(clk), .reset(reset), .bin_count(bin_count), .err_clr(err_clr),
    .up_down(ud_a), .step(step_a), .hold(hold_a), .jump_err(err_a),
    .position(pos_a), .rev_count(rev_a)
  );

  cntr_dir_decoder #(.WIDTH(W), .POS_W(16), .REV_W(2)) dut_b (
    .clk(clk), .reset(reset), .bin_count(bin_count), .err_clr(err_clr),
    .up_down(ud_b), .step(step_b), .hold(hold_b), .jump_err(err_b),
    .position(pos_b), .rev_count(rev_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int cur, d;
    cur = int'(bin_count);
    if (reset) begin
      m_mode = 0; m_prev = 0; m_pos = 0; m_rev = 0; m_rev2 = 0;
      m_have = 0; m_dir = 0; m_step = 0; m_hold = 0; m_err = 0;
    end else begin
      m_step = 0;
      m_hold = 0;
      if (m_mode == 0) begin
        m_prev = cur;
        m_mode = 1;
      end else if (m_mode == 1) begin
        d = (cur - m_prev + MOD) % MOD;
        m_prev = cur;
        if (d == 1 || d == MOD - 1) begin
          if (m_have && (bit'(d == MOD - 1) != m_dir)) begin
            if (m_rev < 255) m_rev++;
            if (m_rev2 < 3) m_rev2++;
          end
          m_dir  = (d == MOD - 1);
          m_have = 1;
          m_step = 1;
          m_pos  = (m_pos + (m_dir ? 65535 : 1)) % 65536;
        end else if (d == 0) begin
          m_hold = 1;
        end else begin
          m_err  = 1;
          m_mode = 2;
        end
      end else begin
        m_prev = cur;
        if (err_clr) begin
          m_err  = 0;
          m_mode = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("up_down",   int'(ud_a),   int'(m_dir));
      chk("step",      int'(step_a), int'(m_step));
      chk("hold",      int'(hold_a), int'(m_hold));
      chk("jump_err",  int'(err_a),  int'(m_err));
      chk("position",  int'(pos_a),  m_pos);
      chk("rev_count", int'(rev_a),  m_rev);
      chk("step_b",    int'(step_b), int'(m_step));
      chk("pos_b",     int'(pos_b),  m_pos);
      chk("rev_b",     int'(rev_b),  m_rev2);
      chk("ud_b",      int'(ud_b),   int'(m_dir));
      chk("err_b",     int'(err_b),  int'(m_err));
      chk("hold_b",    int'(hold_b), int'(m_hold));
    end
  end

  task automatic drive(input int bc, input bit clr, input bit rst);
    bin_count = W'(bc % MOD);
    err_clr   = clr;
    reset     = rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 1);
  endtask

  initial begin
    int cur, r;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_pos", int'(pos_a), 0);
    chk("reset_rev", int'(rev_a), 0);
    chk("reset_step", int'(step_a), 0);

    // basic up then reversals
    drive(0, 0, 0);
    chk("init_no_step", int'(step_a), 0);
    drive(1, 0, 0); drive(2, 0, 0); drive(3, 0, 0);
    chk("up3_pos", int'(pos_a), 3);
    chk("up3_dir", int'(ud_a), 0);
    chk("up3_rev", int'(rev_a), 0);
    drive(2, 0, 0); drive(1, 0, 0);
    chk("dn_dir", int'(ud_a), 1);
    chk("dn_pos", int'(pos_a), 1);
    chk("dn_rev", int'(rev_a), 1);
    drive(2, 0, 0);
    chk("rev2", int'(rev_a), 2);
    chk("rev2_pos", int'(pos_a), 2);

    // wraps
    do_reset();
    drive(6, 0, 0); drive(7, 0, 0); drive(0, 0, 0); drive(1, 0, 0);
    chk("upwrap_pos", int'(pos_a), 3);
    do_reset();
    drive(1, 0, 0); drive(0, 0, 0); drive(7, 0, 0); drive(6, 0, 0);
    chk("dnwrap_pos", int'(pos_a), 16'hFFFD);
    chk("dnwrap_rev", int'(rev_a), 0);

    // hold
    do_reset();
    drive(4, 0, 0); drive(4, 0, 0);
    chk("hold1", int'(hold_a), 1);
    drive(4, 0, 0);
    chk("hold2", int'(hold_a), 1);
    chk("hold2_step", int'(step_a), 0);
    drive(5, 0, 0);
    chk("hold_then_step", int'(pos_a), 1);

    // jump and recovery
    do_reset();
    drive(2, 0, 0); drive(3, 0, 0); drive(6, 0, 0);
    chk("jump_flag", int'(err_a), 1);
    drive(7, 0, 0);
    chk("err_no_step", int'(step_a), 0);
    chk("err_pos", int'(pos_a), 1);
    drive(7, 1, 0);
    chk("err_clr", int'(err_a), 0);
    drive(0, 0, 0);
    chk("reseed_no_step", int'(step_a), 0);
    drive(1, 0, 0);
    chk("resume_step", int'(step_a), 1);
    chk("resume_pos", int'(pos_a), 2);

    // mid-run reset
    do_reset();
    drive(0, 0, 0); drive(1, 0, 0); drive(2, 0, 0); drive(3, 0, 0);
    drive(2, 0, 0); drive(3, 0, 0); drive(4, 0, 0); drive(5, 0, 0);
    chk("pre_rst_pos", int'(pos_a), 5);
    chk("pre_rst_rev", int'(rev_a), 2);
    drive(6, 0, 1);
    chk("rst_pos", int'(pos_a), 0);
    chk("rst_rev", int'(rev_a), 0);
    chk("rst_dir", int'(ud_a), 0);

    // reversal saturation on the REV_W=2 instance
    drive(0, 0, 0);
    for (int i = 1; i <= 6; i++) drive(i % 2, 0, 0);
    chk("sat_rev_b", int'(rev_b), 3);
    chk("sat_rev_a", int'(rev_a), 5);

    // random walk with occasional jumps, clears and resets
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      cur = (cur + 1) % MOD;
      else if (r < 80) cur = (cur + MOD - 1) % MOD;
      else if (r < 92) cur = cur;
      else             cur = int'($urandom_range(0, MOD - 1));
      drive(cur, ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
